ex_operand_stage: RTL and testbench



---
 rtl/pipeline_pkg.sv | 54 +++++
 rtl/fwd_select.sv | 26 ++
 rtl/ex_operand_stage.sv | 197 +++++++++++++++++++
 tb/tb_ex_operand_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the RV32 pipeline stages.
// Holds the ALU operation encodings, the forward-select enum, the
// registered ID/EX bundle and a small register-match helper.
package pipeline_pkg;

  localparam int PKG_DATA_WIDTH    = 32;
  localparam int PKG_OPCODE_LENGTH = 4;
  localparam int PKG_REG_ADDR_W    = 5;

  localparam logic [PKG_OPCODE_LENGTH-1:0] ALU_AND = 4'b0000;
  localparam logic [PKG_OPCODE_LENGTH-1:0] ALU_OR  = 4'b0001;
  localparam logic [PKG_OPCODE_LENGTH-1:0] ALU_ADD = 4'b0010;
  localparam logic [PKG_OPCODE_LENGTH-1:0] ALU_SUB = 4'b0011;
  localparam logic [PKG_OPCODE_LENGTH-1:0] ALU_XOR = 4'b0100;
  localparam logic [PKG_OPCODE_LENGTH-1:0] ALU_SLL = 4'b0101;
  localparam logic [PKG_OPCODE_LENGTH-1:0] ALU_SRL = 4'b0110;
  localparam logic [PKG_OPCODE_LENGTH-1:0] ALU_EQ  = 4'b1000;

  // Where an operand comes from: the registered value, the EX/MEM
  // result, or the MEM/WB write-back value.
  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_e;

  // Everything the EX stage needs, captured at the ID/EX boundary.
  // An all-zero value is a bubble and also the reset value.
  typedef struct packed {
    logic                         valid;
    logic [PKG_REG_ADDR_W-1:0]    rs1_addr;
    logic [PKG_REG_ADDR_W-1:0]    rs2_addr;
    logic [PKG_REG_ADDR_W-1:0]    rd;
    logic [PKG_DATA_WIDTH-1:0]    rs1_data;
    logic [PKG_DATA_WIDTH-1:0]    rs2_data;
    logic [PKG_DATA_WIDTH-1:0]    imm;
    logic [PKG_OPCODE_LENGTH-1:0] alu_op;
    logic                         alu_src;
    logic                         mem_read;
    logic                         mem_write;
    logic                         reg_write;
  } id_ex_t;

  // True when a writing stage targets the given source register.
  // x0 is hard-wired to zero, so a write to it never counts as a match.
  function automatic logic regMatch(
    input logic                      writeEn,
    input logic [PKG_REG_ADDR_W-1:0] dstAddr,
    input logic [PKG_REG_ADDR_W-1:0] srcAddr
  );
    return writeEn && (dstAddr != '0) && (dstAddr == srcAddr);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Forward-select decision for a single EX operand.
// The younger EX/MEM result wins over the older MEM/WB value.
module fwd_select
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = PKG_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] rs_addr_i,
  input  logic                  exmem_reg_write_i,
  input  logic [REG_ADDR_W-1:0] exmem_rd_i,
  input  logic                  memwb_reg_write_i,
  input  logic [REG_ADDR_W-1:0] memwb_rd_i,
  output fwd_sel_e              sel_o
);

  // Pick the newest in-flight producer of this operand, if any.
  always_comb begin
    sel_o = FWD_NONE;
    if (regMatch(exmem_reg_write_i, exmem_rd_i, rs_addr_i)) begin
      sel_o = FWD_MEM;
    end else if (regMatch(memwb_reg_write_i, memwb_rd_i, rs_addr_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX boundary of the 5-stage RV32 pipeline: registers the decoded
// instruction, resolves EX/MEM and MEM/WB forwarding for the ALU and
// store data, and detects load-use hazards.
// Optional build macro EX_PERF_CNT_EN adds saturating stall and
// forwarding performance counters.
module ex_operand_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH    = PKG_DATA_WIDTH,
  parameter int OPCODE_LENGTH = PKG_OPCODE_LENGTH,
  parameter int REG_ADDR_W    = PKG_REG_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [REG_ADDR_W-1:0]    id_rs1_addr,
  input  logic [REG_ADDR_W-1:0]    id_rs2_addr,
  input  logic [REG_ADDR_W-1:0]    id_rd_addr,
  input  logic [DATA_WIDTH-1:0]    id_rs1_data,
  input  logic [DATA_WIDTH-1:0]    id_rs2_data,
  input  logic [DATA_WIDTH-1:0]    id_imm,
  input  logic [OPCODE_LENGTH-1:0] id_alu_op,
  input  logic                     id_alu_src,
  input  logic                     id_mem_read,
  input  logic                     id_mem_write,
  input  logic                     id_reg_write,
  input  logic                     flush,
  input  logic                     exmem_reg_write,
  input  logic [REG_ADDR_W-1:0]    exmem_rd,
  input  logic [DATA_WIDTH-1:0]    exmem_alu_result,
  input  logic                     memwb_reg_write,
  input  logic [REG_ADDR_W-1:0]    memwb_rd,
  input  logic [DATA_WIDTH-1:0]    memwb_wb_data,
  output logic                     load_use_stall,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    ex_store_data,
  output logic [REG_ADDR_W-1:0]    ex_rd,
  output logic                     ex_valid,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write
`ifdef EX_PERF_CNT_EN
  ,
  output logic [31:0]              perf_stall_cnt,
  output logic [31:0]              perf_fwd_cnt
`endif
);

  id_ex_t exStage_q;
  id_ex_t exStage_d;

  logic [DATA_WIDTH-1:0] rs1Capture;
  logic [DATA_WIDTH-1:0] rs2Capture;
  logic [DATA_WIDTH-1:0] fwdRs1;
  logic [DATA_WIDTH-1:0] fwdRs2;
  fwd_sel_e              rs1Sel;
  fwd_sel_e              rs2Sel;

  // A load in EX whose destination is read by the instruction in ID must
  // hold ID for one cycle; a flush kills ID anyway, so it masks the stall.
  always_comb begin
    load_use_stall = exStage_q.valid && exStage_q.mem_read &&
                     (exStage_q.rd != '0) && id_valid &&
                     ((id_rs1_addr == exStage_q.rd) ||
                      (id_rs2_addr == exStage_q.rd)) &&
                     !flush;
  end

  // Register-file read happens before the MEM/WB write lands, so a value
  // being written back this cycle is taken directly at capture time.
  always_comb begin
    rs1Capture = regMatch(memwb_reg_write, memwb_rd, id_rs1_addr) ?
                 memwb_wb_data : id_rs1_data;
    rs2Capture = regMatch(memwb_reg_write, memwb_rd, id_rs2_addr) ?
                 memwb_wb_data : id_rs2_data;
  end

  // Next ID/EX contents: a flush or stall inserts an all-zero bubble,
  // otherwise the ID fields are taken as they are.
  always_comb begin
    exStage_d = '0;
    if (!flush && !load_use_stall) begin
      exStage_d.valid     = id_valid;
      exStage_d.rs1_addr  = id_rs1_addr;
      exStage_d.rs2_addr  = id_rs2_addr;
      exStage_d.rd        = id_rd_addr;
      exStage_d.rs1_data  = rs1Capture;
      exStage_d.rs2_data  = rs2Capture;
      exStage_d.imm       = id_imm;
      exStage_d.alu_op    = id_alu_op;
      exStage_d.alu_src   = id_alu_src;
      exStage_d.mem_read  = id_mem_read;
      exStage_d.mem_write = id_mem_write;
      exStage_d.reg_write = id_reg_write;
    end
  end

  // ID/EX pipeline register; reset produces the same value as a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      exStage_q <= '0;
    end else begin
      exStage_q <= exStage_d;
    end
  end

  fwd_select #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd_rs1 (
    .rs_addr_i        (exStage_q.rs1_addr),
    .exmem_reg_write_i(exmem_reg_write),
    .exmem_rd_i       (exmem_rd),
    .memwb_reg_write_i(memwb_reg_write),
    .memwb_rd_i       (memwb_rd),
    .sel_o            (rs1Sel)
  );

  fwd_select #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd_rs2 (
    .rs_addr_i        (exStage_q.rs2_addr),
    .exmem_reg_write_i(exmem_reg_write),
    .exmem_rd_i       (exmem_rd),
    .memwb_reg_write_i(memwb_reg_write),
    .memwb_rd_i       (memwb_rd),
    .sel_o            (rs2Sel)
  );

  // Apply the forward selections to the registered operand values.
  always_comb begin
    fwdRs1 = exStage_q.rs1_data;
    fwdRs2 = exStage_q.rs2_data;
    unique case (rs1Sel)
      FWD_MEM: fwdRs1 = exmem_alu_result;
      FWD_WB:  fwdRs1 = memwb_wb_data;
      default: fwdRs1 = exStage_q.rs1_data;
    endcase
    unique case (rs2Sel)
      FWD_MEM: fwdRs2 = exmem_alu_result;
      FWD_WB:  fwdRs2 = memwb_wb_data;
      default: fwdRs2 = exStage_q.rs2_data;
    endcase
  end

  // ALU operands and downstream controls; store data always uses rs2
  // even when the ALU takes the immediate as its second operand.
  always_comb begin
    SrcA          = fwdRs1;
    SrcB          = exStage_q.alu_src ? exStage_q.imm : fwdRs2;
    Operation     = exStage_q.alu_op;
    ex_store_data = fwdRs2;
    ex_rd         = exStage_q.rd;
    ex_valid      = exStage_q.valid;
    ex_reg_write  = exStage_q.reg_write;
    ex_mem_read   = exStage_q.mem_read;
    ex_mem_write  = exStage_q.mem_write;
  end

`ifdef EX_PERF_CNT_EN
  logic [31:0] perfStallCnt_q;
  logic [31:0] perfStallCnt_d;
  logic [31:0] perfFwdCnt_q;
  logic [31:0] perfFwdCnt_d;
  logic        anyForward;

  // Counters stick at all-ones instead of wrapping, so a long run never
  // reports a misleadingly small value.
  always_comb begin
    anyForward     = (rs1Sel != FWD_NONE) || (rs2Sel != FWD_NONE);
    perfStallCnt_d = perfStallCnt_q;
    perfFwdCnt_d   = perfFwdCnt_q;
    if (load_use_stall && (perfStallCnt_q != 32'hFFFF_FFFF)) begin
      perfStallCnt_d = perfStallCnt_q + 32'd1;
    end
    if (exStage_q.valid && anyForward && (perfFwdCnt_q != 32'hFFFF_FFFF)) begin
      perfFwdCnt_d = perfFwdCnt_q + 32'd1;
    end
  end

  // Performance counter registers, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      perfStallCnt_q <= '0;
      perfFwdCnt_q   <= '0;
    end else begin
      perfStallCnt_q <= perfStallCnt_d;
      perfFwdCnt_q   <= perfFwdCnt_d;
    end
  end

  assign perf_stall_cnt = perfStallCnt_q;
  assign perf_fwd_cnt   = perfFwdCnt_q;
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed self-checking bench for ex_operand_stage (default build).
module tb_ex_operand_stage;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic [4:0]  id_rd_addr;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] id_imm;
  logic [3:0]  id_alu_op;
  logic        id_alu_src;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_reg_write;
  logic        flush;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_alu_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_wb_data;
  logic        load_use_stall;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [3:0]  Operation;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_valid;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;

  int checksTotal;
  int checksPassed;

  ex_operand_stage dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs1_addr     (id_rs1_addr),
    .id_rs2_addr     (id_rs2_addr),
    .id_rd_addr      (id_rd_addr),
    .id_rs1_data     (id_rs1_data),
    .id_rs2_data     (id_rs2_data),
    .id_imm          (id_imm),
    .id_alu_op       (id_alu_op),
    .id_alu_src      (id_alu_src),
    .id_mem_read     (id_mem_read),
    .id_mem_write    (id_mem_write),
    .id_reg_write    (id_reg_write),
    .flush           (flush),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_alu_result(exmem_alu_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_wb_data   (memwb_wb_data),
    .load_use_stall  (load_use_stall),
    .SrcA            (SrcA),
    .SrcB            (SrcB),
    .Operation       (Operation),
    .ex_store_data   (ex_store_data),
    .ex_rd           (ex_rd),
    .ex_valid        (ex_valid),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .ex_mem_write    (ex_mem_write)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checksTotal++;
    if (observed === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive the ID-stage instruction fields.
  task automatic applyStimulus(input logic v, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd,
                               input logic [31:0] d1, input logic [31:0] d2,
                               input logic [31:0] imm, input logic [3:0] op,
                               input logic src, input logic mr,
                               input logic mw, input logic rw);
    id_valid     = v;
    id_rs1_addr  = rs1;
    id_rs2_addr  = rs2;
    id_rd_addr   = rd;
    id_rs1_data  = d1;
    id_rs2_data  = d2;
    id_imm       = imm;
    id_alu_op    = op;
    id_alu_src   = src;
    id_mem_read  = mr;
    id_mem_write = mw;
    id_reg_write = rw;
  endtask

  // Drive the EX/MEM and MEM/WB write-back buses.
  task automatic applyBypass(input logic exw, input logic [4:0] exrd,
                             input logic [31:0] exres, input logic mww,
                             input logic [4:0] mwrd, input logic [31:0] mwdata);
    exmem_reg_write  = exw;
    exmem_rd         = exrd;
    exmem_alu_result = exres;
    memwb_reg_write  = mww;
    memwb_rd         = mwrd;
    memwb_wb_data    = mwdata;
  endtask

  // Advance past one rising edge; inputs change #1 after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checksTotal  = 0;
    checksPassed = 0;
    flush        = 1'b0;
    reset        = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    applyBypass(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    #1;

    // Reset then idle
    checkOutput("rst_SrcA", SrcA, 32'd0);
    checkOutput("rst_SrcB", SrcB, 32'd0);
    checkOutput("rst_Operation", {28'd0, Operation}, 32'd0);
    checkOutput("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("rst_ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
    checkOutput("rst_stall", {31'd0, load_use_stall}, 32'd0);
    checkOutput("rst_store", ex_store_data, 32'd0);

    // add x3 <- x1 + x2 with EX/MEM forward of x1
    applyStimulus(1, 1, 2, 3, 32'd5, 32'd7, 32'd0, 4'b0010, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    #1;
    checkOutput("nofwd_SrcA", SrcA, 32'd5);
    applyBypass(1, 5'd1, 32'd100, 0, 0, 0);
    #1;
    checkOutput("exmem_SrcA", SrcA, 32'd100);
    checkOutput("exmem_SrcB", SrcB, 32'd7);
    checkOutput("add_Operation", {28'd0, Operation}, 32'd2);
    checkOutput("add_ex_rd", {27'd0, ex_rd}, 32'd3);
    checkOutput("add_ex_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("add_ex_reg_write", {31'd0, ex_reg_write}, 32'd1);

    // Double hazard on x1: EX/MEM wins; x0 or disabled write falls to MEM/WB
    applyBypass(1, 5'd1, 32'd100, 1, 5'd1, 32'd200);
    #1;
    checkOutput("double_SrcA", SrcA, 32'd100);
    applyBypass(1, 5'd0, 32'd100, 1, 5'd1, 32'd200);
    #1;
    checkOutput("x0_exmem_SrcA", SrcA, 32'd200);
    applyBypass(0, 5'd1, 32'd100, 1, 5'd1, 32'd200);
    #1;
    checkOutput("exmem_off_SrcA", SrcA, 32'd200);
    applyBypass(0, 5'd0, 32'd100, 1, 5'd2, 32'd300);
    #1;
    checkOutput("wb_SrcB", SrcB, 32'd300);

    // Write-back bypass at capture time
    applyStimulus(1, 4, 0, 6, 32'd11, 32'd0, 32'd0, 4'b0100, 0, 0, 0, 1);
    applyBypass(0, 0, 0, 1, 5'd4, 32'd44);
    tick();
    applyBypass(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    #1;
    checkOutput("capwb_SrcA", SrcA, 32'd44);
    checkOutput("capwb_Operation", {28'd0, Operation}, 32'd4);

    // Load-use: lw x5 in EX, ID reads x5 through rs2
    applyStimulus(1, 6, 0, 5, 32'd1000, 32'd0, 32'd8, 4'b0010, 1, 1, 0, 1);
    tick();
    applyStimulus(1, 7, 5, 8, 32'd1, 32'd2, 32'd0, 4'b0011, 0, 0, 0, 1);
    #1;
    checkOutput("lu_stall", {31'd0, load_use_stall}, 32'd1);
    checkOutput("lu_SrcA", SrcA, 32'd1000);
    checkOutput("lu_SrcB_imm", SrcB, 32'd8);
    checkOutput("lu_ex_mem_read", {31'd0, ex_mem_read}, 32'd1);
    tick();
    checkOutput("bub_ex_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("bub_ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
    checkOutput("bub_ex_mem_read", {31'd0, ex_mem_read}, 32'd0);
    checkOutput("bub_stall", {31'd0, load_use_stall}, 32'd0);
    checkOutput("bub_Operation", {28'd0, Operation}, 32'd0);
    tick();
    checkOutput("after_ex_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("after_ex_rd", {27'd0, ex_rd}, 32'd8);
    checkOutput("after_Operation", {28'd0, Operation}, 32'd3);

    // Load writing x0 never stalls
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 4'b0010, 0, 1, 0, 1);
    tick();
    applyStimulus(1, 0, 0, 9, 0, 0, 0, 4'b0010, 0, 0, 0, 1);
    #1;
    checkOutput("x0_load_stall", {31'd0, load_use_stall}, 32'd0);

    // Flush while a load-use hazard is present
    applyStimulus(1, 6, 0, 5, 32'd0, 32'd0, 32'd4, 4'b0010, 1, 1, 0, 1);
    tick();
    applyStimulus(1, 5, 0, 7, 32'd0, 32'd0, 32'd0, 4'b0001, 0, 0, 1, 0);
    #1;
    checkOutput("pre_flush_stall", {31'd0, load_use_stall}, 32'd1);
    flush = 1'b1;
    #1;
    checkOutput("flush_stall", {31'd0, load_use_stall}, 32'd0);
    tick();
    flush = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    #1;
    checkOutput("flush_ex_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("flush_ex_rd", {27'd0, ex_rd}, 32'd0);
    checkOutput("flush_ex_mem_write", {31'd0, ex_mem_write}, 32'd0);

    // alu_src with forwarded rs2 going to store data
    applyStimulus(1, 1, 2, 10, 32'd33, 32'd3, 32'hFFFF_FFFC, 4'b0010, 1, 0, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    applyBypass(1, 5'd2, 32'd9, 0, 0, 0);
    #1;
    checkOutput("src_SrcB", SrcB, 32'hFFFF_FFFC);
    checkOutput("src_store", ex_store_data, 32'd9);
    checkOutput("src_SrcA", SrcA, 32'd33);
    checkOutput("src_ex_mem_write", {31'd0, ex_mem_write}, 32'd1);
    applyBypass(0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("src_store_nofwd", ex_store_data, 32'd3);

    // Mid-stream reset clears a valid EX instruction
    applyStimulus(1, 1, 2, 12, 32'd1, 32'd2, 32'd0, 4'b1000, 0, 0, 0, 1);
    tick();
    checkOutput("mid_pre_valid", {31'd0, ex_valid}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    #1;
    checkOutput("mid_rst_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("mid_rst_Operation", {28'd0, Operation}, 32'd0);
    checkOutput("mid_rst_ex_rd", {27'd0, ex_rd}, 32'd0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
